freq_timer_bank: RTL
====================

Name: freq_timer_bank

Overview:
- Parametrised bank of NUM_CH independent frequency timers, successor to the single-channel audio frequency timer.
- A shared programmable prescaler drives every channel. Each channel has:
  - its own reload period, with shadowed period updates;
  - a restart strobe;
  - one-shot and periodic modes;
  - a single-cycle tick output and a 50%-duty toggle output.
- Sits between the sound register file and the channel waveform generators (square, wave, noise sequencers), which consume the ticks.

Parameters:
- NUM_CH, 4, number of timer channels.
- PERIOD_W, 17, width of each channel's period and counter.
- PRESC_W, 8, width of the prescaler divide value.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- presc_div  input  PRESC_W  base tick fires every presc_div+1 clocks.
- ch_enable  input  NUM_CH  per-channel run enable (level).
- ch_oneshot  input  NUM_CH  1 = stop after first expiry, 0 = periodic.
- ch_restart  input  NUM_CH  one-cycle strobe: reload counter immediately from ch_period.
- ch_period_we  input  NUM_CH  one-cycle write strobe for ch_period.
- ch_period  input  NUM_CH*PERIOD_W  packed periods; channel i occupies bits [i*PERIOD_W +: PERIOD_W].
- ch_tick  output  NUM_CH  one-clock pulse on each expiry.
- ch_clk  output  NUM_CH  toggles on each expiry.
- ch_done  output  NUM_CH  sticky: one-shot expired; cleared by restart.

Behaviour:
- Reset (async, reset_n low): all of the following are 0:
  - prescaler count and base tick;
  - all counters, shadow periods and active periods;
  - ch_tick, ch_clk, ch_done.
- Prescaler:
  - Free-running up-counter.
  - base_tick=1 for one clock when count==presc_div, then count wraps to 0.
  - presc_div=0 makes base_tick=1 every clock.
  - A change to presc_div takes effect when the count next reaches the new value. If count already exceeds the new value, the counter wraps naturally at 2^PRESC_W; no glitch suppression.
- Period write: ch_period_we[i] latches ch_period slice into shadow[i] on that clock.
- Active period load: active[i] takes shadow[i] at the next natural reload or restart. There is no mid-count change, which removes the old abort-on-change behaviour.
- Per-channel counter:
  - Down-counter, decremented only on base_tick while running.
  - Running = ch_enable[i] & ~ch_done[i] & (active[i]!=0).
- Expiry: on base_tick with counter==0 and running:
  - ch_tick[i]=1 for exactly that following clock (registered, latency 1 clock after the expiring base_tick edge);
  - ch_clk[i] inverts;
  - counter reloads to shadow[i]-1, and active<=shadow.
- Zero period: a period value of 0 means the channel is stopped. Counter holds; no ticks.
- One-shot: on the first expiry, ch_done[i] sets and the channel stops with ch_clk frozen. ch_done stays set until ch_restart[i].
- Restart:
  - The clock after the strobe: counter=ch_period slice-1 if ch_period_we[i] is also set that cycle, else shadow[i]-1.
  - active and shadow are updated accordingly.
  - ch_clk[i] and ch_done[i] are cleared. No tick is issued that cycle.
  - Restart wins over a simultaneous expiry.
- ch_enable low: counter holds its value and outputs freeze. Re-enable resumes the count without reload.
- Period 1: expires every base_tick, so ch_clk frequency = base_tick rate / 2.
- Arithmetic: all counter arithmetic is unsigned PERIOD_W. Reload with shadow=0 never occurs, because running requires nonzero.
- Channels are fully independent apart from the shared base_tick.

Decomposition:
- Package freq_timer_pkg holds:
  - the default widths;
  - the typedef period_t = logic [PERIOD_W-1:0];
  - the typedef ch_state_t {counter, active, shadow, clk, done}.
- One sub-module, freq_timer_channel, holds one channel's counter/shadow/one-shot logic with scalar ports.
- The top instantiates the prescaler inline and generates NUM_CH channels.

Test Plan:
- Reset: drive reset_n low mid-count (ch0 counter=3) -> all outputs 0 asynchronously; counters 0 after release.
- Periodic: presc_div=0, ch0 period=4, enable -> ch_tick[0] every 4 clocks; ch_clk[0] period 8 clocks; ch1..3 (period 0) silent.
- Prescaler: presc_div=2, ch1 period=3 -> tick every 9 clocks; change presc_div to 0 mid-run -> tick spacing becomes 3 clocks after the next prescaler wrap.
- Shadow: ch2 period=5 running, write period 2 mid-count -> current interval completes at 5; next intervals are 2.
- One-shot: ch3 oneshot=1, period=3 -> single tick at 3 base ticks, ch_done[3]=1, no further ticks; ch_restart[3] -> done=0, ch_clk=0, tick again after 3.
- Simultaneous: ch_restart coincident with expiry -> no tick that cycle, counter=shadow-1. ch_enable low for 10 clocks -> counter frozen, resumes exact remaining count.

Source files
------------

// File: rtl/freq_timer_pkg.sv
// Shared widths and per-channel state types for the frequency timer bank.
// Pure declarations: no logic, no latency, no flow control.
package freq_timer_pkg;

  localparam int NUM_CH_DEF   = 4;
  localparam int PERIOD_W_DEF = 17;
  localparam int PRESC_W_DEF  = 8;

  typedef logic [PERIOD_W_DEF-1:0] period_t;

  typedef struct packed {
    period_t counter;
    period_t active;
    period_t shadow;
    logic    clk;
    logic    done;
  } ch_state_t;

endpackage

// File: rtl/freq_timer_channel.sv
// One timer channel: shadowed period, down-counter, one-shot stop, tick/toggle outputs.
// Tick is registered one clock after the expiring base tick; no backpressure, restart wins over expiry.
module freq_timer_channel
  import freq_timer_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    base_tick_i,
  input  logic    enable_i,
  input  logic    oneshot_i,
  input  logic    restart_i,
  input  logic    period_we_i,
  input  period_t period_i,
  output logic    tick_o,
  output logic    clk_o,
  output logic    done_o
);

  ch_state_t state_q, state_d;
  logic      tick_q, tick_d;
  logic      running;
  logic      expire;
  period_t   load_val;

  assign running  = enable_i & ~state_q.done & (state_q.active != '0);
  assign expire   = base_tick_i & running & (state_q.counter == '0);
  assign load_val = period_we_i ? period_i : state_q.shadow;

  always_comb begin
    state_d = state_q;
    tick_d  = 1'b0;
    if (period_we_i) begin
      state_d.shadow = period_i;
    end
    if (restart_i) begin
      state_d.counter = load_val - period_t'(1);
      state_d.active  = load_val;
      state_d.shadow  = load_val;
      state_d.clk     = 1'b0;
      state_d.done    = 1'b0;
    end else if (expire) begin
      // Reload uses the shadow as it stood before any same-cycle write.
      state_d.counter = state_q.shadow - period_t'(1);
      state_d.active  = state_q.shadow;
      state_d.clk     = ~state_q.clk;
      tick_d          = 1'b1;
      if (oneshot_i) begin
        state_d.done = 1'b1;
      end
    end else if (base_tick_i && running) begin
      state_d.counter = state_q.counter - period_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_o = tick_q;
  assign clk_o  = state_q.clk;
  assign done_o = state_q.done;

endmodule

// File: rtl/freq_timer_bank.sv
// Bank of NUM_CH frequency timers sharing one programmable prescaler.
// Base tick is registered; channel ticks follow one clock later; no backpressure.
module freq_timer_bank
  import freq_timer_pkg::*;
#(
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int PRESC_W  = PRESC_W_DEF
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [PRESC_W-1:0]         presc_div,
  input  logic [NUM_CH-1:0]          ch_enable,
  input  logic [NUM_CH-1:0]          ch_oneshot,
  input  logic [NUM_CH-1:0]          ch_restart,
  input  logic [NUM_CH-1:0]          ch_period_we,
  input  logic [NUM_CH*PERIOD_W-1:0] ch_period,
  output logic [NUM_CH-1:0]          ch_tick,
  output logic [NUM_CH-1:0]          ch_clk,
  output logic [NUM_CH-1:0]          ch_done
);

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic               base_tick_q;
  logic               presc_hit;

  // Lowering presc_div below the current count lets the counter run to 2^PRESC_W.
  assign presc_hit   = (presc_cnt_q == presc_div);
  assign presc_cnt_d = presc_hit ? '0 : presc_cnt_q + PRESC_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt_q <= '0;
      base_tick_q <= 1'b0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      base_tick_q <= presc_hit;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    freq_timer_channel u_ch (
      .clk_i       (clock),
      .rst_ni      (reset_n),
      .base_tick_i (base_tick_q),
      .enable_i    (ch_enable[i]),
      .oneshot_i   (ch_oneshot[i]),
      .restart_i   (ch_restart[i]),
      .period_we_i (ch_period_we[i]),
      .period_i    (period_t'(ch_period[i*PERIOD_W +: PERIOD_W])),
      .tick_o      (ch_tick[i]),
      .clk_o       (ch_clk[i]),
      .done_o      (ch_done[i])
    );
  end

endmodule
